// File: rtl/ahb_xfer_ctrl_pkg.sv
// Shared definitions for the AHB transfer controller: FSM encoding, size codes, defaults.
package ahb_xfer_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        RETRY = 2'd2,
        DONE  = 2'd3
    } xfer_state_t;

    localparam logic [2:0] SIZE_BYTE = 3'd0;
    localparam logic [2:0] SIZE_HALF = 3'd1;
    localparam logic [2:0] SIZE_WORD = 3'd2;

    localparam int unsigned FIFO_DEPTH_DEF = 4;

    // Any size code above word is treated as a word transfer.
    function automatic logic [2:0] eff_size(input logic [2:0] s);
        return (s > SIZE_WORD) ? SIZE_WORD : s;
    endfunction

endpackage

// File: rtl/ahb_sync_fifo.sv
// Single-clock FIFO with registered occupancy count and full/empty flags.
module ahb_sync_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic                     HCLK,
    input  logic                     HRST_N,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    // Push while full and pop while empty are dropped.
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rptr];

    // Storage array, no reset needed.
    always_ff @(posedge HCLK) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    // Pointers and occupancy; depth is a power of two so pointers wrap naturally.
    always_ff @(posedge HCLK or negedge HRST_N) begin
        if (!HRST_N) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/ahb_xfer_ctrl.sv
// Command-driven AHB master-side transfer sequencer with write and read data buffers.
module ahb_xfer_ctrl
    import ahb_xfer_ctrl_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic        HCLK,
    input  logic        HRST_N,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [7:0]  cmd_len,
    input  logic [2:0]  cmd_size,
    input  logic [31:0] wdata,
    input  logic        wvalid,
    output logic        wready,
    output logic [31:0] rdata,
    output logic        rvalid,
    input  logic        rready,
    output logic        done,
    output logic        Request,
    output logic        Burst,
    output logic        Busy,
    output logic        Write,
    output logic [2:0]  Size,
    output logic [31:0] Addr,
    output logic [31:0] DataIn,
    input  logic [31:0] DataOut,
    input  logic        Grant,
    input  logic        Okay,
    input  logic        Retry
);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    xfer_state_t r_state;
    logic        r_write;
    logic [31:0] r_addr;
    logic [8:0]  r_total;
    logic [2:0]  r_size;
    logic [8:0]  r_issued;
    logic [8:0]  r_acked;

    logic          w_run;
    logic          w_request;
    logic          w_grant;
    logic          w_okay;
    logic          w_retry;
    logic [8:0]    w_outstanding;
    logic [8:0]    w_acked_nxt;
    logic [31:0]   w_offset;
    logic [CW-1:0] w_wcount;
    logic [CW-1:0] w_rcount;
    logic          w_wfull;
    logic          w_wempty;
    logic          w_rfull;
    logic          w_rempty;
    logic          w_unused;

    assign w_run         = (r_state == RUN);
    assign w_outstanding = r_issued - r_acked;
    assign w_request     = w_run && (r_issued < r_total);
    assign w_grant       = Grant && w_request;
    assign w_okay        = Okay && w_run && (r_acked < r_issued);
    assign w_retry       = Retry && w_run;
    assign w_acked_nxt   = r_acked + 9'(w_okay);
    assign w_offset      = {23'd0, r_acked} << r_size;

    assign cmd_ready = (r_state == IDLE);
    assign done      = (r_state == DONE);
    assign Request   = w_request;
    assign Burst     = (r_total > 9'd1);
    assign Write     = r_write;
    assign Size      = r_size;
    assign Addr      = r_addr + w_offset;
    assign wready    = !w_wfull;
    assign rvalid    = !w_rempty;
    assign w_unused  = w_wempty ^ w_rfull;

    // Write: stall when buffered data cannot cover another beat. Read: stall when the
    // read buffer could not absorb every beat already in flight plus one more.
    always_comb begin
        Busy = 1'b0;
        if (w_run) begin
            if (r_write) begin
                Busy = ({1'b0, w_outstanding} >= 10'(w_wcount));
            end else begin
                Busy = (10'(w_rcount) + {1'b0, w_outstanding}) >= 10'(FIFO_DEPTH);
            end
        end
    end

    // Command FSM with issue/acknowledge beat counters.
    always_ff @(posedge HCLK or negedge HRST_N) begin
        if (!HRST_N) begin
            r_state  <= IDLE;
            r_write  <= 1'b0;
            r_addr   <= '0;
            r_total  <= '0;
            r_size   <= SIZE_BYTE;
            r_issued <= '0;
            r_acked  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cmd_valid) begin
                        r_write  <= cmd_write;
                        r_addr   <= cmd_addr;
                        r_total  <= {1'b0, cmd_len} + 9'd1;
                        r_size   <= eff_size(cmd_size);
                        r_issued <= '0;
                        r_acked  <= '0;
                        r_state  <= RUN;
                    end
                end
                RUN: begin
                    r_acked <= w_acked_nxt;
                    if (w_retry) begin
                        // Rewind issue count; Addr already tracks the failed beat.
                        r_issued <= w_acked_nxt;
                        r_state  <= RETRY;
                    end else begin
                        r_issued <= r_issued + 9'(w_grant);
                        if (w_acked_nxt == r_total) begin
                            r_state <= DONE;
                        end
                    end
                end
                RETRY:   r_state <= RUN;
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    ahb_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_wfifo (
        .HCLK    (HCLK),
        .HRST_N  (HRST_N),
        .i_push  (wvalid),
        .i_wdata (wdata),
        .i_pop   (w_okay && r_write),
        .o_rdata (DataIn),
        .o_full  (w_wfull),
        .o_empty (w_wempty),
        .o_count (w_wcount)
    );

    ahb_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_rfifo (
        .HCLK    (HCLK),
        .HRST_N  (HRST_N),
        .i_push  (w_okay && !r_write),
        .i_wdata (DataOut),
        .i_pop   (rready),
        .o_rdata (rdata),
        .o_full  (w_rfull),
        .o_empty (w_rempty),
        .o_count (w_rcount)
    );

endmodule

// File: tb/tb_ahb_xfer_ctrl.sv
// Bench for ahb_xfer_ctrl: table of directed commands, random commands, reset corner cases.
module tb_ahb_xfer_ctrl;
    localparam int DEPTH = 4;

    logic        HCLK = 1'b0;
    logic        HRST_N;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic [2:0]  cmd_size;
    logic [31:0] wdata, rdata, Addr, DataIn, DataOut;
    logic        wvalid, wready, rvalid, rready, done;
    logic        Request, Burst, Busy, Write, Grant, Okay, Retry;
    logic [2:0]  Size;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        int          retry_beat;
        int          preload;
        int          w_hold;
        logic [31:0] last_addr;
        bit          need_busy;
    } vec_t;

    vec_t vt[8];

    always #5 HCLK = ~HCLK;

    ahb_xfer_ctrl dut (
        .HCLK      (HCLK),
        .HRST_N    (HRST_N),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .cmd_size  (cmd_size),
        .wdata     (wdata),
        .wvalid    (wvalid),
        .wready    (wready),
        .rdata     (rdata),
        .rvalid    (rvalid),
        .rready    (rready),
        .done      (done),
        .Request   (Request),
        .Burst     (Burst),
        .Busy      (Busy),
        .Write     (Write),
        .Size      (Size),
        .Addr      (Addr),
        .DataIn    (DataIn),
        .DataOut   (DataOut),
        .Grant     (Grant),
        .Okay      (Okay),
        .Retry     (Retry)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic clear_inputs();
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_size = '0;
        wvalid = 1'b0; wdata = '0; rready = 1'b0;
        Grant = 1'b0; Okay = 1'b0; Retry = 1'b0; DataOut = '0;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_cmd_ready"}, {31'd0, cmd_ready}, 1);
        chk({tag, "_Request"},   {31'd0, Request},   0);
        chk({tag, "_Busy"},      {31'd0, Busy},      0);
        chk({tag, "_done"},      {31'd0, done},      0);
        chk({tag, "_rvalid"},    {31'd0, rvalid},    0);
        chk({tag, "_wready"},    {31'd0, wready},    1);
    endtask

    // Runs one command; the bus side grants/acks at random, the model tracks beats and buffers.
    task automatic run_cmd(input bit wr, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input int retry_beat, input int preload,
                           input int w_hold, input bit rready_en, input int max_cyc,
                           input bit expect_finish, input bit chk_last,
                           input logic [31:0] last_addr, output int busy_cycles);
        int total, step, pushed, wocc, rocc, rpop, issued, acked;
        bit gap, retried, finished, exp_req, exp_busy, grant, do_ok, do_rt, push, pop;
        logic [2:0]  esize;
        logic [31:0] wq[$];
        logic [31:0] rq[$];
        total = int'(len) + 1;
        esize = (size > 3'd2) ? 3'd2 : size;
        step = 1 << esize;
        pushed = 0; wocc = 0; rocc = 0; rpop = 0; issued = 0; acked = 0;
        gap = 0; retried = 0; finished = 0; busy_cycles = 0;
        for (int k = 0; k < total; k++) wq.push_back($urandom);

        @(negedge HCLK);
        for (int p = 0; p < preload; p++) begin
            wvalid = 1'b1; wdata = wq[pushed]; pushed++; wocc++;
            @(negedge HCLK);
        end
        wvalid = 1'b0;
        chk("accept_cmd_ready", {31'd0, cmd_ready}, 1);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_len = len; cmd_size = size;
        @(negedge HCLK);
        cmd_valid = 1'b0;

        for (int cyc = 0; cyc < max_cyc && !finished; cyc++) begin
            exp_req = !gap && (issued < total);
            if (wr) exp_busy = (wocc <= issued - acked);
            else    exp_busy = (rocc + issued - acked >= DEPTH);
            chk("Request", {31'd0, Request}, {31'd0, exp_req});
            if (!gap) chk("Busy", {31'd0, Busy}, {31'd0, exp_busy});
            chk("done_early", {31'd0, done}, 0);
            chk("cmd_ready_busy", {31'd0, cmd_ready}, 0);
            chk("Burst", {31'd0, Burst}, {31'd0, total > 1});
            chk("Write", {31'd0, Write}, {31'd0, wr});
            chk("Size", {29'd0, Size}, {29'd0, esize});
            chk("wready", {31'd0, wready}, {31'd0, wocc < DEPTH});
            chk("rvalid", {31'd0, rvalid}, {31'd0, rocc > 0});
            if (exp_req && exp_busy) busy_cycles++;

            grant = exp_req && !exp_busy && ($urandom_range(0, 3) != 0);
            do_ok = 0; do_rt = 0;
            if (issued > acked && $urandom_range(0, 3) != 0) begin
                if (acked == retry_beat && !retried) do_rt = 1;
                else do_ok = 1;
            end
            if (do_rt) grant = 0;
            if (do_ok) begin
                chk("Addr", Addr, addr + 32'(acked * step));
                if (chk_last && acked == total - 1) chk("Addr_last", Addr, last_addr);
                if (wr) begin
                    chk("DataIn", DataIn, wq[acked]);
                end else begin
                    DataOut = $urandom;
                    rq.push_back(DataOut);
                end
            end
            push = wr && pushed < total && cyc >= w_hold && wocc < DEPTH &&
                   ($urandom_range(0, 1) != 0);
            wvalid = push;
            if (push) wdata = wq[pushed];
            pop = !wr && rready_en && rocc > 0 && ($urandom_range(0, 1) != 0);
            if (pop) chk("rdata", rdata, rq[rpop]);
            Grant = grant; Okay = do_ok; Retry = do_rt; rready = pop;

            @(negedge HCLK);
            issued += int'(grant);
            acked  += int'(do_ok);
            if (wr) begin
                wocc += int'(push) - int'(do_ok);
                pushed += int'(push);
            end else begin
                rocc += int'(do_ok) - int'(pop);
                rpop += int'(pop);
            end
            if (do_rt) begin
                issued = acked; retried = 1; gap = 1;
            end else begin
                gap = 0;
            end
            if (acked == total) finished = 1;
        end
        clear_inputs();

        if (expect_finish) begin
            chk("finished_in_budget", {31'd0, finished}, 1);
            if (finished) begin
                chk("done_pulse", {31'd0, done}, 1);
                chk("done_Request", {31'd0, Request}, 0);
                @(negedge HCLK);
                chk("done_drop", {31'd0, done}, 0);
                chk("back_idle", {31'd0, cmd_ready}, 1);
                if (!wr) begin
                    while (rpop < total && rocc > 0) begin
                        chk("drain_rvalid", {31'd0, rvalid}, 1);
                        chk("drain_rdata", rdata, rq[rpop]);
                        rready = 1'b1;
                        @(negedge HCLK);
                        rready = 1'b0;
                        rpop++; rocc--;
                    end
                    chk("rdata_count", rpop, total);
                    chk("rfifo_empty", {31'd0, rvalid}, 0);
                end else begin
                    chk("wfifo_drained", {31'd0, wready}, 1);
                end
            end
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bc, total, step, tmp;
        bit wr;
        logic [2:0]  sz;
        logic [7:0]  ln;
        logic [31:0] ad;

        clear_inputs();
        HRST_N = 1'b0;
        repeat (3) @(negedge HCLK);
        chk_quiet("rst");
        chk("rst_Burst", {31'd0, Burst}, 0);
        chk("rst_Write", {31'd0, Write}, 0);
        chk("rst_Size", {29'd0, Size}, 0);
        chk("rst_Addr", Addr, 0);
        HRST_N = 1'b1;
        @(negedge HCLK);

        vt[0] = '{1'b0, 32'h0000_0100, 8'd3,   3'd2, -1, 0, 0,  32'h0000_010C, 1'b0};
        vt[1] = '{1'b1, 32'h0000_0040, 8'd0,   3'd2, -1, 1, 0,  32'h0000_0040, 1'b0};
        vt[2] = '{1'b1, 32'h0000_0200, 8'd7,   3'd2, -1, 2, 20, 32'h0000_021C, 1'b1};
        vt[3] = '{1'b0, 32'h0000_0100, 8'd3,   3'd2, 2,  0, 0,  32'h0000_010C, 1'b0};
        vt[4] = '{1'b0, 32'h0000_0301, 8'd5,   3'd0, -1, 0, 0,  32'h0000_0306, 1'b0};
        vt[5] = '{1'b1, 32'h0000_0402, 8'd3,   3'd1, 3,  0, 0,  32'h0000_0408, 1'b0};
        vt[6] = '{1'b0, 32'h0000_0800, 8'd15,  3'd7, -1, 0, 0,  32'h0000_083C, 1'b0};
        vt[7] = '{1'b1, 32'h0000_0C00, 8'd255, 3'd0, -1, 0, 0,  32'h0000_0CFF, 1'b0};

        for (int i = 0; i < 8; i++) begin
            run_cmd(vt[i].wr, vt[i].addr, vt[i].len, vt[i].size, vt[i].retry_beat,
                    vt[i].preload, vt[i].w_hold, 1'b1, (int'(vt[i].len) + 1) * 16 + 200,
                    1'b1, 1'b1, vt[i].last_addr, bc);
            if (vt[i].need_busy) chk("busy_seen", {31'd0, bc > 0}, 1);
        end

        // Random commands, each kept inside one 1 KB region.
        for (int i = 0; i < 25; i++) begin
            wr = 1'($urandom_range(0, 1));
            sz = 3'($urandom_range(0, 7));
            ln = 8'($urandom_range(0, 31));
            total = int'(ln) + 1;
            step = 1 << ((sz > 3'd2) ? 2 : int'(sz));
            tmp = $urandom;
            ad = (32'(tmp) & 32'hFFFF_FC00) + 32'($urandom_range(0, 200) * step);
            run_cmd(wr, ad, ln, sz,
                    ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, int'(ln))) : -1,
                    wr ? int'($urandom_range(0, (total < DEPTH) ? total : DEPTH)) : 0,
                    int'($urandom_range(0, 5)), 1'b1, total * 16 + 200, 1'b1, 1'b0, '0, bc);
        end

        // Read with no consumer stalls on a full read buffer; reset then abandons it.
        run_cmd(1'b0, 32'h0000_0100, 8'd7, 3'd2, -1, 0, 0, 1'b0, 60, 1'b0, 1'b0, '0, bc);
        chk("stall_busy_seen", {31'd0, bc > 0}, 1);
        chk("stall_rvalid", {31'd0, rvalid}, 1);
        chk("stall_Busy", {31'd0, Busy}, 1);
        chk("stall_Request", {31'd0, Request}, 1);
        HRST_N = 1'b0;
        #1;
        chk_quiet("midrst");
        @(negedge HCLK);
        HRST_N = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge HCLK);
            chk("post_rst_done", {31'd0, done}, 0);
            chk("post_rst_rvalid", {31'd0, rvalid}, 0);
            chk("post_rst_idle", {31'd0, cmd_ready}, 1);
        end

        run_cmd(vt[0].wr, vt[0].addr, vt[0].len, vt[0].size, -1, 0, 0, 1'b1, 300,
                1'b1, 1'b1, vt[0].last_addr, bc);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ahb_xfer_ctrl.md
AHB_XFER_CTRL -- requirements
Module: ahb_xfer_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, giving the write-data and read-data buffer depth (power of 2, minimum 2).
REQ-002 SHALL have these ports:
- HCLK  in  1  clock
- HRST_N  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when high together with cmd_valid
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  32  start byte address, aligned to cmd_size
- cmd_len  in  8  beats minus 1 (0 = single beat, 255 = 256 beats)
- cmd_size  in  3  0/1/2 = byte/half/word; other values treated as 2
- wdata  in  32  write-data push
- wvalid  in  1  write-data push strobe
- wready  out  1  write FIFO not full
- rdata  out  32  read-data pop
- rvalid  out  1  read FIFO not empty
- rready  in  1  read-data pop strobe
- done  out  1  one-cycle pulse when all beats of the command have been acknowledged
- Request, Burst, Busy, Write  out  1 each  master-side controls
- Size  out  3  master-side transfer size
- Addr  out  32  master-side address
- DataIn  out  32  master-side write data
- DataOut  in  32  master-side read data
- Grant  in  1  address phase accepted this cycle
- Okay  in  1  data phase completed this cycle
- Retry  in  1  data phase answered RETRY/SPLIT

Function
REQ-003 SHALL use FSM states IDLE, RUN, RETRY, DONE.
REQ-004 IDLE: cmd_ready=1; on cmd_valid, SHALL latch write, addr, len+1 (9-bit total), size and go to RUN next cycle.
REQ-005 SHALL keep counters issued (Grant count) and acked (Okay count), both 9-bit and cleared on command accept.
REQ-006 RUN: Request=1 while issued<total; Request SHALL drop in the same cycle that issued reaches total.
REQ-007 Burst SHALL be 1 when total>1, otherwise 0; Write and Size SHALL be held constant for the whole command.
REQ-008 Addr SHALL equal latched addr + acked*(1<<size), truncated to 32 bits, with no 1 KB boundary splitting; caller guarantees that a command does not cross a 1 KB boundary.
REQ-009 Write command: Busy SHALL be 1 when write-FIFO occupancy <= (issued-acked), i.e. no data is available for the next beat.
REQ-010 Read command: Busy SHALL be 1 when read-FIFO occupancy + (issued-acked) >= FIFO_DEPTH.
REQ-011 DataIn SHALL equal the write-FIFO head, popped on Okay during a write command.
REQ-012 On Okay during a read command, DataOut SHALL be pushed to the read FIFO in the same cycle; overflow is prevented by REQ-010.
REQ-013 Grant and Okay in the same cycle SHALL both count.
REQ-014 On Retry in RUN: issued:=acked, go to RETRY for one cycle with Request=0, then return to RUN; Addr already points at the failed beat.
REQ-015 RUN→DONE when acked reaches total; DONE drives done=1 for one cycle, then goes to IDLE.
REQ-016 Retry on the last beat SHALL re-issue that beat only; done SHALL NOT pulse until its Okay.
REQ-017 wvalid while full and rready while empty SHALL be ignored; FIFOs SHALL support push and pop in the same cycle.

Reset
REQ-018 Asynchronous HRST_N low SHALL force:
- FSM to IDLE, counters to 0, both FIFOs empty
- cmd_ready=1, Request=0, Burst=0, Busy=0, Write=0, Size=0, Addr=0, done=0, rvalid=0, wready=1
REQ-019 Reset mid-command SHALL abandon the command with no done pulse.

Structure
REQ-020 A shared package SHALL hold the FSM state encoding, the size codes and the FIFO_DEPTH default.
REQ-021 Both buffers SHALL be instances of sub-module ahb_sync_fifo (32-bit, registered count, full/empty flags).

Verification
REQ-022 Read, addr 0x100, len 3, size 2, Okay on each Grant → Addr 0x100/104/108/10C, 4 rdata in order, done after 4th Okay.
REQ-023 Write, len 0, one wdata preloaded → Burst=0, single Grant, FIFO popped on Okay, done pulse, back in IDLE.
REQ-024 Write, len 7, only 2 words preloaded → Busy=1 after 2 issues until the next wvalid, 8 beats total.
REQ-025 Read, len 3, Retry on beat 2 (addr 0x108) → Request=0 for one cycle, re-issue from 0x108, exactly 4 rdata.
REQ-026 Read, len 7, rready=0 → Busy once outstanding+occupancy=4, no data lost; HRST_N pulse mid-burst → IDLE, FIFOs empty, no done.
